// File: rtl/ball_motion_if.sv
// Signal bundle between the ball-motion stage and its neighbours (paddle stage, brick
// logic, renderer). The master drives the game inputs; the slave (ball_motion) drives the ball state.
interface ball_motion_if;
   logic       tick;
   logic       start;
   logic [9:0] padx;
   logic [9:0] pady;
   logic       padcol;
   logic [2:0] padang;
   logic       brick_hit;
   logic       brick_vert;
   logic [9:0] ballx;
   logic [9:0] bally;
   logic [1:0] lives;
   logic       ball_lost;
   logic       game_over;
   logic       moving;

   modport master (
      output tick, start, padx, pady, padcol, padang, brick_hit, brick_vert,
      input  ballx, bally, lives, ball_lost, game_over, moving
   );

   modport slave (
      input  tick, start, padx, pady, padcol, padang, brick_hit, brick_vert,
      output ballx, bally, lives, ball_lost, game_over, moving
   );
endinterface

// File: rtl/ball_motion.sv
// Ball serve/launch/motion/reflection stage with lives and game-over tracking.
// Optional macro BALL_SPEEDUP_EN: every 8 honored paddle bounces shorten the step divider.
module ball_motion #(
   parameter int unsigned SCREEN_W   = 320,
   parameter int unsigned BALL_SZ    = 4,
   parameter int unsigned LOST_Y     = 239,
   parameter int unsigned PAD_W      = 80,
   parameter int unsigned LIVES_INIT = 3,
   parameter int unsigned MOVE_DIV   = 2
) (
   input logic          clk_i,
   input logic          rst_ni,
   ball_motion_if.slave bus
);

   localparam logic signed [10:0] XMax      = 11'(SCREEN_W - BALL_SZ);
   localparam logic signed [10:0] LostY     = 11'(LOST_Y);
   localparam logic [9:0]         HalfPad   = 10'(PAD_W / 2);
   localparam logic [9:0]         ServeX    = 10'(100 + PAD_W / 2);
   localparam logic [1:0]         DivInit   = 2'(MOVE_DIV);
   localparam logic [1:0]         LivesInit = 2'(LIVES_INIT);

   typedef enum logic [1:0] {StServe, StMove, StOver} state_e;

   state_e            state_q;
   logic [9:0]        ballx_q, bally_q;
   logic signed [2:0] vx_q;
   logic              vy_neg_q;   // 1: travelling up (vy = -1)
   logic [1:0]        div_q;
   logic [1:0]        lives_q;
   logic              ball_lost_q;
   logic [1:0]        div_max;

`ifdef BALL_SPEEDUP_EN
   logic [2:0] hits_q;
   logic [1:0] div_max_q;
   assign div_max = div_max_q;
`else
   assign div_max = DivInit;
`endif

   // Reflection and position for a move step, evaluated every cycle.
   logic signed [2:0]  vx_r, step_vx;
   logic               vy_neg_r, step_vy_neg;
   logic               pad_hit, step_lost;
   logic signed [10:0] nx, ny;
   logic [9:0]         step_x, step_y;

   always_comb begin
      vx_r     = vx_q;
      vy_neg_r = vy_neg_q;
      pad_hit  = 1'b0;
      if (bus.padcol && !vy_neg_q) begin
         pad_hit  = 1'b1;
         vy_neg_r = 1'b1;
         case (bus.padang)
            3'd0:    vx_r = -3'sd2;
            3'd1:    vx_r = -3'sd1;
            3'd2:    vx_r = 3'sd0;
            3'd3:    vx_r = 3'sd1;
            3'd4:    vx_r = 3'sd2;
            default: vx_r = vx_q;
         endcase
      end else if (bus.brick_hit) begin
         if (bus.brick_vert) vy_neg_r = !vy_neg_q;
         else                vx_r     = -vx_q;
      end

      nx      = $signed({1'b0, ballx_q}) + {{8{vx_r[2]}}, vx_r};
      step_vx = vx_r;
      if (nx < 0) begin
         step_x  = 10'd0;
         step_vx = -vx_r;
      end else if (nx > XMax) begin
         step_x  = XMax[9:0];
         step_vx = -vx_r;
      end else begin
         step_x  = nx[9:0];
      end

      ny          = $signed({1'b0, bally_q}) + (vy_neg_r ? 11'sh7FF : 11'sd1);
      step_vy_neg = vy_neg_r;
      step_lost   = 1'b0;
      if (vy_neg_r && (bally_q == 10'd0)) begin
         step_y      = 10'd1;
         step_vy_neg = 1'b0;
      end else begin
         step_y    = ny[9:0];
         step_lost = (ny >= LostY);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StServe;
         ballx_q     <= ServeX;
         bally_q     <= 10'd199;
         vx_q        <= 3'sd1;
         vy_neg_q    <= 1'b1;
         div_q       <= 2'd0;
         lives_q     <= LivesInit;
         ball_lost_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
         hits_q      <= 3'd0;
         div_max_q   <= DivInit;
`endif
      end else begin
         ball_lost_q <= 1'b0;
         if (bus.tick) begin
            case (state_q)
               StServe: begin
                  ballx_q <= bus.padx + HalfPad;
                  bally_q <= bus.pady - 10'd1;
                  if (!bus.start) begin
                     vx_q     <= 3'sd1;
                     vy_neg_q <= 1'b1;
                     div_q    <= 2'd0;
                     state_q  <= StMove;
                  end
               end
               StMove: begin
                  if (div_q >= div_max - 2'd1) begin
                     div_q <= 2'd0;
                     if (step_lost) begin
                        // Position is left where it was; SERVE re-places it on the next tick.
                        ball_lost_q <= 1'b1;
                        if (lives_q == 2'd1) begin
                           lives_q <= 2'd0;
                           state_q <= StOver;
                        end else begin
                           lives_q <= lives_q - 2'd1;
                           state_q <= StServe;
                        end
`ifdef BALL_SPEEDUP_EN
                        hits_q    <= 3'd0;
                        div_max_q <= DivInit;
`endif
                     end else begin
                        ballx_q  <= step_x;
                        bally_q  <= step_y;
                        vx_q     <= step_vx;
                        vy_neg_q <= step_vy_neg;
`ifdef BALL_SPEEDUP_EN
                        if (pad_hit) begin
                           hits_q <= hits_q + 3'd1;
                           if ((hits_q == 3'd7) && (div_max_q > 2'd1)) begin
                              div_max_q <= div_max_q - 2'd1;
                           end
                        end
`endif
                     end
                  end else begin
                     div_q <= div_q + 2'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifndef BALL_SPEEDUP_EN
   logic unused_pad_hit;
   assign unused_pad_hit = pad_hit;
`endif

   assign bus.ballx     = ballx_q;
   assign bus.bally     = bally_q;
   assign bus.lives     = lives_q;
   assign bus.ball_lost = ball_lost_q;
   assign bus.game_over = (state_q == StOver);
   assign bus.moving    = (state_q == StMove);

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Ball-position stage that consumes the paddle's collision outputs (padcol, padang) and produces ballx/bally, which feed back into the paddle block and the renderer.
- Handles serve, launch, per-frame motion, and reflection off the walls, paddle and bricks.
- Handles ball loss, lives and game-over.
- Runs on the system clock and advances only on the frame tick.

Parameters:
- SCREEN_W, 320, playfield width in pixels
- BALL_SZ, 4, ball edge length; right wall limit is SCREEN_W-BALL_SZ
- LOST_Y, 239, bally at or beyond this value means the ball is lost
- PAD_W, 80, paddle width, used for the serve position
- LIVES_INIT, 3, lives loaded at reset (2-bit counter)
- MOVE_DIV, 2, frame ticks per ball step (1..3)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- tick  in  1  one-cycle frame-tick enable (60 Hz)
- start  in  1  active-low serve button
- padx  in  10  paddle left x
- pady  in  10  paddle top y
- padcol  in  1  paddle collision flag from the paddle stage
- padang  in  3  paddle hit zone 0..4, left to right
- brick_hit  in  1  brick collision flag, sampled on a move step
- brick_vert  in  1  1 = brick hit on top/bottom face (flip vy), 0 = side face (flip vx)
- ballx  out  10  ball x
- bally  out  10  ball y
- lives  out  2  remaining lives
- ball_lost  out  1  one-clk pulse when a life is lost
- game_over  out  1  high in state OVER
- moving  out  1  high in state MOVE

Behaviour:
- Reset (async, rst=0):
  - state=SERVE, lives=LIVES_INIT, vx=+1, vy=-1, divider counter=0.
  - ballx=100+PAD_W/2, bally=199.
  - ball_lost=0, game_over=0, moving=0.
- All updates occur on clk edges where tick=1, except ball_lost clearing.
- ball_lost is high for exactly one clk.
- SERVE state:
  - Each tick: ballx=padx+PAD_W/2, bally=pady-1.
  - start==0 on a tick: vx=+1, vy=-1, divider=0 -> MOVE.
- MOVE state:
  - Divider counts ticks 0..MOVE_DIV-1; a move step occurs on the tick where divider==MOVE_DIV-1, after which divider wraps to 0.
  - Reflection is resolved first on a step, then position is updated with the new velocity.
  - Priority on a step: paddle > brick > walls > bottom.
  - Paddle: padcol=1 and vy=+1 sets vy=-1 and vx by padang:
    - 0 -> -2, 1 -> -1, 2 -> 0, 3 -> +1, 4 -> +2.
    - padang 5..7 -> vx unchanged.
    - padcol while vy=-1 is ignored.
  - Brick: brick_hit=1 -> flip vy if brick_vert=1, else flip vx.
  - Left wall: ballx+vx<0 -> ballx=0, vx=-vx.
  - Right wall: ballx+vx>SCREEN_W-BALL_SZ -> ballx=SCREEN_W-BALL_SZ, vx=-vx.
  - Top: bally=0 with vy=-1 -> vy=+1, bally=1.
  - Arithmetic: 11-bit signed intermediate; no wrap allowed on ballx/bally.
  - vy magnitude is always 1, so bally passes through every row (the paddle stage uses an exact-equality y match).
  - Bottom: bally+vy>=LOST_Y -> ball_lost pulse, lives=lives-1, -> SERVE; if lives was 1 -> lives=0, -> OVER.
- OVER state:
  - Ball frozen; game_over=1.
  - Only reset exits this state.
- Simultaneous padcol and brick_hit: paddle wins; the brick flag is dropped for that step.
- Corner case: when both walls and top apply on the same step, both axes reflect.
- Reset mid-flight returns to SERVE immediately, with no pulse.

Optional Feature:
- Macro BALL_SPEEDUP_EN.
- Defined:
  - 3-bit paddle-hit counter increments on each honored paddle bounce.
  - When it wraps from 7 to 0, the effective divider reloads as max(div-1,1).
  - Counter and divider restore to MOVE_DIV on SERVE entry.
- Undefined: divider fixed at MOVE_DIV; no hit counter is built.

Test Plan:
- Serve: reset, padx=100, pady=200, start=1 for 5 ticks -> ballx=140, bally=199. Then start=0 one tick -> moving=1, vx=+1, vy=-1.
- Paddle angle: ball descending, padcol=1, padang=0 on a step -> vy=-1, vx=-2, ballx decreases by 2 per step. Repeat with padang=4 -> vx=+2.
- Right wall: ballx=315, vx=+2 on a step -> ballx=316, next step ballx=314 (vx=-2). Left wall: ballx=1, vx=-2 -> ballx=0, then vx=+2.
- Priority: padcol=1 and brick_hit=1, brick_vert=0, on the same step with vy=+1 -> only the paddle reflection applies, vx from padang.
- Loss: lives=3, ball at bally=238, vy=+1 -> ball_lost 1-clk pulse, lives=2, state SERVE. After the third loss -> lives=0, game_over=1, position frozen despite start=0.
- BALL_SPEEDUP_EN: MOVE_DIV=2, 8 paddle bounces -> steps occur every tick. Ball loss -> divider back to 2.
